// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
//
// 1-bit half adder tile. Drives the combinational sum/carry of the two
// dedicated inputs, a registered copy of both, and a 4-bit wrapping count of
// registered carry events.
//
// Ports:
//   clk      in   1  tile clock, registers update on the rising edge
//   rst_n    in   1  asynchronous reset, ACTIVE-HIGH despite the name
//                    (1 = reset)
//   ena      in   1  tile enable, registers update only when 1
//   ui_in    in   8  [0]=a, [1]=b, [2]=synchronous counter clear,
//                    [7:3] ignored
//   uo_out   out  8  [0]=sum (comb), [1]=carry (comb), [2]=sum_q,
//                    [3]=carry_q, [7:4]=cnt
//   uio_in   in   8  ignored
//   uio_out  out  8  constant 8'h00
//   uio_oe   out  8  constant 8'h00 (bidirectional pins are all inputs)
//
// There is no handshake on this block: inputs are sampled on every enabled
// rising edge and outputs are valid continuously.
// -----------------------------------------------------------------------------
module half_adder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic       a;
   logic       b;
   logic       clr;
   logic       sum;
   logic       carry;

   logic       sum_d;
   logic       sum_q;
   logic       carry_d;
   logic       carry_q;
   logic [3:0] cnt_d;
   logic [3:0] cnt_q;

   assign a   = ui_in[0];
   assign b   = ui_in[1];
   assign clr = ui_in[2];

   // Combinational path: independent of clock, enable and reset.
   assign sum   = a ^ b;
   assign carry = a & b;

   always_comb begin
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      if (ena) begin
         sum_d   = sum;
         carry_d = carry;
         // Clear wins over an increment on the same edge; the counter
         // advances on the same edge that captures carry_q = 1.
         if (clr) begin
            cnt_d = 4'd0;
         end else if (carry) begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   // rst_n is active-high: registers clear immediately while it is 1.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         sum_q   <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= 4'd0;
      end else begin
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   assign uo_out  = {cnt_q, carry_q, sum_q, carry, sum};
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

   // Inputs the tile deliberately ignores.
   logic unused_inputs;
   assign unused_inputs = &{1'b0, ui_in[7:3], uio_in};

endmodule

// File: tb/tb_half_adder.sv
// -----------------------------------------------------------------------------
// tb_half_adder
//
// Directed bench for half_adder. The driver applies hand-computed vectors and
// pushes the expected value of the selected output into a queue, then raises
// chk_ev; an independent monitor pops and compares against the DUT.
// Output selectors: 0 = uo_out, 1 = uio_out, 2 = uio_oe.
// -----------------------------------------------------------------------------
module tb_half_adder;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   half_adder dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;   // posedges at 5, 15, 25, ...

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int         sel_q[$];
   string      name_q[$];
   event       chk_ev;
   int         n_vec = 0;
   int         n_err = 0;
   logic       toggle_uio = 1'b0;

   task automatic expect_out(input int sel, input logic [7:0] exp, input string name);
      exp_q.push_back(exp);
      sel_q.push_back(sel);
      name_q.push_back(name);
      -> chk_ev;
   endtask

   // Monitor: compares in the same time step the driver raised the event.
   initial begin
      forever begin
         @(chk_ev);
         while (exp_q.size() > 0) begin
            logic [7:0] e;
            logic [7:0] act;
            int         s;
            string      nm;
            e  = exp_q.pop_front();
            s  = sel_q.pop_front();
            nm = name_q.pop_front();
            case (s)
               1:       act = uio_out;
               2:       act = uio_oe;
               default: act = uo_out;
            endcase
            n_vec++;
            if (act !== e) begin
               n_err++;
               $display("FAIL %s: got 8'h%02h expected 8'h%02h at %0t", nm, act, e, $time);
            end
         end
      end
   end

   // uio_in noise while enabled: it must never affect any output.
   initial begin
      uio_in = 8'h00;
      forever begin
         #3;
         if (toggle_uio) uio_in = 8'($urandom_range(0, 255));
      end
   end

   // Watchdog.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- driver tasks ----------------
   // Drive on the falling edge, well away from the active edge.
   task automatic drive(input logic [7:0] ui, input logic en);
      @(negedge clk);
      ui_in = ui;
      ena   = en;
      #1;
   endtask

   // Advance past the next rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      #2;
      @(negedge clk);
      rst_n = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] tt_comb[4]  = '{8'h00, 8'h01, 8'h05, 8'h06};
   logic [7:0] tt_reg[4]   = '{8'h00, 8'h05, 8'h05, 8'h1A};

   initial begin
      rst_n = 1'b1;
      ena   = 1'b1;
      ui_in = 8'h03;
      toggle_uio = 1'b1;

      // 1. Reset with a=b=1: comb carry visible, registers zero.
      #2;
      expect_out(0, 8'h02, "reset_uo_out");
      expect_out(1, 8'h00, "reset_uio_out");
      expect_out(2, 8'h00, "reset_uio_oe");
      tick();
      expect_out(0, 8'h02, "reset_held_through_edge");

      // 2. Truth table, released from reset.
      @(negedge clk);
      ui_in = 8'h00;
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(8'(i), 1'b1);
         expect_out(0, tt_comb[i], $sformatf("truth_comb_%0d", i));
         tick();
         expect_out(0, tt_reg[i], $sformatf("truth_reg_%0d", i));
      end

      // 3. Counter and wrap: 17 edges with a=b=1 after reset.
      drive(8'h03, 1'b1);
      do_reset();
      #1;
      expect_out(0, 8'h02, "count_after_reset");
      for (int k = 1; k <= 17; k++) begin
         tick();
         expect_out(0, {4'(k % 16), 4'hA}, $sformatf("count_step_%0d", k));
      end

      // 4. Enable gating: cnt = 1, registers 10.
      drive(8'h03, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick();
         expect_out(0, 8'h1A, $sformatf("ena_low_%0d", k));
      end
      drive(8'h00, 1'b0);
      expect_out(0, 8'h18, "ena_low_comb_follows");
      tick();
      expect_out(0, 8'h18, "ena_low_hold");

      // 5. Clear priority: bring cnt from 1 to 5.
      drive(8'h03, 1'b1);
      for (int k = 0; k < 4; k++) tick();
      expect_out(0, 8'h5A, "cnt_at_5");
      drive(8'h07, 1'b1);
      tick();
      expect_out(0, 8'h0A, "clear_priority");
      drive(8'h01, 1'b1);
      tick();
      expect_out(0, 8'h05, "after_clear_sum_q");
      // Upper ui_in bits ignored (bit 2 low, a=1 b=0).
      drive(8'hF9, 1'b1);
      expect_out(0, 8'h05, "ui_upper_ignored_comb");
      tick();
      expect_out(0, 8'h05, "ui_upper_ignored_reg");

      // 6. Async reset mid-run at cnt = 9.
      drive(8'h03, 1'b1);
      for (int k = 0; k < 9; k++) tick();
      expect_out(0, 8'h9A, "cnt_at_9");
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      expect_out(0, 8'h02, "async_reset_immediate");
      expect_out(1, 8'h00, "async_reset_uio_out");
      expect_out(2, 8'h00, "async_reset_uio_oe");
      tick();
      expect_out(0, 8'h02, "async_reset_held");
      @(negedge clk);
      rst_n = 1'b0;
      tick();
      expect_out(0, 8'h1A, "first_capture_after_release");

      // Drain check with a bound.
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) #1;
      if (exp_q.size() > 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      toggle_uio = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
